// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_stream
//  Purpose  : Read-side adapter for the gray-pointer async FIFO. Lives in the
//             FIFO read clock domain. Hides the FIFO's one-cycle registered
//             read latency behind a 2-entry output buffer and presents a
//             valid/ready stream with full throughput and lossless
//             backpressure. Generates m_last from a programmable frame
//             length and keeps beat/frame counters for status registers.
//  Ports    :
//    rd_clk        in   read-domain clock
//    rd_rst        in   synchronous active-high reset
//    fifo_rd_en    out  read request to the FIFO
//    fifo_rd_data  in   FIFO read data (valid the cycle after a read)
//    fifo_rd_empty in   FIFO empty flag
//    m_valid       out  output beat valid
//    m_ready       in   consumer ready
//    m_data        out  output beat data
//    m_last        out  last beat of the current frame
//    frame_len     in   beats per frame, 0 = unframed
//    beats_out     out  completed handshakes (wraps at 2^32)
//    frames_out    out  completed frames (wraps at 2^LEN_WIDTH)
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    output logic [31:0]           beats_out,
    output logic [LEN_WIDTH-1:0]  frames_out
);

    localparam logic [LEN_WIDTH-1:0] C_LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] C_LEN_ZERO = '0;

    // Output buffer: r_head is presented on m_data, r_tail holds the second
    // entry when two words are buffered.
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [1:0]            r_buf_cnt;
    logic                  r_inflight;

    logic [LEN_WIDTH-1:0]  r_beat_cnt;
    logic [LEN_WIDTH-1:0]  r_len_q;
    logic [LEN_WIDTH-1:0]  r_frames_out;
    logic [31:0]           r_beats_out;

    logic                  w_pop;
    logic                  w_last;
    logic [2:0]            w_committed;

    assign m_valid = (r_buf_cnt != 2'd0);
    assign m_data  = r_head;
    assign w_pop   = m_valid & m_ready;

    // m_last is qualified with m_valid so it is never seen high on an idle bus.
    assign w_last  = m_valid & (r_len_q != C_LEN_ZERO) & (r_beat_cnt == (r_len_q - C_LEN_ONE));
    assign m_last  = w_last;

    // Slots that will be occupied after this edge if no new read is issued.
    // A pop implies buf_cnt >= 1, so the subtraction cannot underflow.
    assign w_committed = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_rd_en  = ~rd_rst & ~fifo_rd_empty & (w_committed < 3'd2);

    assign beats_out  = r_beats_out;
    assign frames_out = r_frames_out;

    // ------------------------------------------------------------------------
    // Buffer and in-flight tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_buf_cnt  <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
            case ({w_pop, r_inflight})
                2'b11: begin
                    // Pop and capture together: occupancy unchanged.
                    if (r_buf_cnt == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= fifo_rd_data;
                    end else begin
                        r_head <= fifo_rd_data;
                    end
                end
                2'b10: begin
                    r_head    <= r_tail;
                    r_buf_cnt <= r_buf_cnt - 2'd1;
                end
                2'b01: begin
                    if (r_buf_cnt == 2'd0) begin
                        r_head <= fifo_rd_data;
                    end else begin
                        r_tail <= fifo_rd_data;
                    end
                    r_buf_cnt <= r_buf_cnt + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Framing and status counters
    // ------------------------------------------------------------------------
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_beat_cnt   <= '0;
            r_len_q      <= frame_len;
            r_frames_out <= '0;
            r_beats_out  <= '0;
        end else begin
            if (w_pop) begin
                r_beats_out <= r_beats_out + 32'd1;
                if (w_last) begin
                    r_beat_cnt   <= '0;
                    r_frames_out <= r_frames_out + C_LEN_ONE;
                    r_len_q      <= frame_len;
                end else if (r_len_q != C_LEN_ZERO) begin
                    r_beat_cnt <= r_beat_cnt + C_LEN_ONE;
                end
            end else if ((r_beat_cnt == C_LEN_ZERO) && !m_valid) begin
                // Idle at a frame start: track frame_len so a new length
                // applies to the next frame without waiting for a boundary.
                r_len_q <= frame_len;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_stream
//  Purpose  : Self-checking bench for fifo_rd_stream. A queue-based FIFO
//             model feeds the DUT; every word pushed into the FIFO is also
//             pushed into an expected queue, and a monitor pops and compares
//             on each output handshake. Framing is predicted by a
//             beat-position model of frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          rd_clk = 1'b0;
    logic          rd_rst = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty = 1'b1;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [LW-1:0] frame_len = '0;
    logic [31:0]   beats_out;
    logic [LW-1:0] frames_out;

    fifo_rd_stream #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .frame_len     (frame_len),
        .beats_out     (beats_out),
        .frames_out    (frames_out)
    );

    always #5 rd_clk = ~rd_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO model and scoreboard
    logic [DW-1:0] mem[$];
    logic [DW-1:0] feed_q[$];
    logic [DW-1:0] exp_q[$];
    int  max_gap    = 0;
    int  gap_left   = 0;
    bit  feed_burst = 0;
    bit  rd_req_s   = 0;
    bit  req_l      = 0;
    int  cyc        = 0;

    always @(posedge rd_clk) cyc++;

    always @(posedge rd_clk) begin
        req_l = rd_req_s;
        #1;
        if (req_l && mem.size() > 0) fifo_rd_data = mem.pop_front();
        if (feed_burst) begin
            while (feed_q.size() > 0) begin
                mem.push_back(feed_q[0]);
                exp_q.push_back(feed_q[0]);
                void'(feed_q.pop_front());
            end
        end else if (gap_left > 0) begin
            gap_left--;
        end else if (feed_q.size() > 0) begin
            mem.push_back(feed_q[0]);
            exp_q.push_back(feed_q[0]);
            void'(feed_q.pop_front());
            gap_left = $urandom_range(0, max_gap);
        end
        fifo_rd_empty = (mem.size() == 0);
    end

    // Monitor / reference model
    int unsigned   reads = 0, pops = 0;
    logic [31:0]   beats_exp = '0;
    logic [LW-1:0] frames_exp = '0;
    int            model_pos = 0, model_len = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [DW-1:0] exp_word;
    bit            exp_last;
    int            n_drop;
    int            phase = 0, seen_phase = 0;
    int            first_rd = -1, first_val = -1, first_pop = -1, last_pop = -1;
    int            ph_reads = 0, ph_pops = 0, ph_lasts = 0;

    always @(negedge rd_clk) begin
        if (phase != seen_phase) begin
            seen_phase = phase;
            first_rd = -1; first_val = -1; first_pop = -1; last_pop = -1;
            ph_reads = 0; ph_pops = 0; ph_lasts = 0;
        end
        rd_req_s = fifo_rd_en;
        if (rd_rst) begin
            check("rd_en_in_reset", fifo_rd_en, 1'b0);
            // Words already read but not delivered are dropped by reset.
            n_drop = int'(reads - pops);
            for (int k = 0; k < n_drop; k++) if (exp_q.size() > 0) void'(exp_q.pop_front());
            reads = 0; pops = 0; beats_exp = '0; frames_exp = '0;
            model_pos = 0; model_len = int'(frame_len); prev_stall = 0;
        end else begin
            if (fifo_rd_empty) check("rd_en_while_empty", fifo_rd_en, 1'b0);
            if (fifo_rd_en) begin
                reads++; ph_reads++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (m_valid && first_val < 0) first_val = cyc;
            if (prev_stall) begin
                check("stall_valid", m_valid, 1'b1);
                check("stall_data", m_data, prev_data);
                check("stall_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got 0x%0h expected no beat", m_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("data", m_data, exp_word);
                end
                exp_last = (model_len != 0) && (model_pos == model_len - 1);
                check("last", m_last, exp_last);
                if (exp_last) begin
                    model_pos = 0;
                    model_len = int'(frame_len);
                    frames_exp = frames_exp + 1'b1;
                    ph_lasts++;
                end else if (model_len != 0) begin
                    model_pos++;
                end
                pops++; ph_pops++; beats_exp = beats_exp + 32'd1;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end else if (model_pos == 0 && !m_valid) begin
                model_len = int'(frame_len);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // Stimulus helpers
    task automatic step();
        @(posedge rd_clk);
        #2;
    endtask

    task automatic push_words(input logic [DW-1:0] base, input int n, input bit seq);
        for (int i = 0; i < n; i++) feed_q.push_back(seq ? base + DW'(i) : DW'($urandom()));
    endtask

    task automatic burst_load(input logic [DW-1:0] base, input int n);
        push_words(base, n, 1'b1);
        feed_burst = 1;
        step();
        feed_burst = 0;
    endtask

    task automatic wait_drain(input string name, input int budget, input bit rnd_ready);
        int k = 0;
        while ((feed_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            k++;
        end
        m_ready = 1'b1;
        step();
        check(name, {31'd0, (feed_q.size() == 0 && exp_q.size() == 0)}, 64'd1);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (!m_valid && k < budget) begin
            step();
            k++;
        end
        check(name, m_valid, 1'b1);
    endtask

    initial begin
        // ---------------- Reset with data waiting in the FIFO ----------------
        rd_rst = 1'b1; m_ready = 1'b1; frame_len = '0;
        step();
        burst_load(32'h100, 8);
        step();
        step();
        phase++;
        rd_rst = 1'b0;
        @(negedge rd_clk);
        check("rst_valid", m_valid, 1'b0);
        check("rst_last", m_last, 1'b0);
        check("rst_data", m_data, 32'h0);
        check("rst_beats", beats_out, 32'd0);
        check("rst_frames", frames_out, 16'd0);

        // ---------------- Streaming ----------------
        wait_drain("stream_drain", 100, 1'b0);
        check("stream_latency", 64'(first_val - first_rd), 64'd2);
        check("stream_consecutive", 64'(last_pop - first_pop), 64'd7);
        check("stream_pops", 64'(ph_pops), 64'd8);
        check("stream_no_last", 64'(ph_lasts), 64'd0);
        check("stream_beats", beats_out, 32'd8);

        // ---------------- Backpressure ----------------
        phase++;
        m_ready = 1'b0;
        burst_load(32'h100, 8);
        wait_valid("bp_valid", 20);
        for (int i = 0; i < 5; i++) step();
        check("bp_reads", 64'(ph_reads), 64'd2);
        check("bp_head", m_data, 32'h100);
        wait_drain("bp_drain", 100, 1'b0);
        check("bp_pops", 64'(ph_pops), 64'd8);
        check("bp_beats", beats_out, 32'd16);

        // ---------------- Framing ----------------
        phase++;
        frame_len = 16'd3;
        step();
        step();
        burst_load(32'h200, 7);
        wait_drain("frame_drain", 100, 1'b0);
        check("frame_lasts", 64'(ph_lasts), 64'd2);
        check("frame_count", frames_out, 16'd2);
        frame_len = 16'd2;
        burst_load(32'h300, 3);
        wait_drain("frame2_drain", 100, 1'b0);
        check("frame2_count", frames_out, frames_exp);

        // ---------------- Bubbles with random ready ----------------
        phase++;
        frame_len = 16'd5;
        max_gap = 4;
        push_words('0, 40, 1'b0);
        wait_drain("bubble_drain", 2000, 1'b1);
        check("bubble_beats", beats_out, beats_exp);
        check("bubble_frames", frames_out, frames_exp);
        max_gap = 0;

        // ---------------- Mid-stream reset ----------------
        m_ready = 1'b0;
        burst_load(32'h400, 6);
        wait_valid("mr_valid", 20);
        phase++;
        rd_rst = 1'b1;
        step();
        rd_rst = 1'b0;
        @(negedge rd_clk);
        check("mr_valid_low", m_valid, 1'b0);
        check("mr_beats", beats_out, 32'd0);
        check("mr_frames", frames_out, 16'd0);
        m_ready = 1'b1;
        wait_drain("mr_drain", 100, 1'b0);
        check("mr_latency", 64'(first_val - first_rd), 64'd2);
        check("mr_pops", 64'(ph_pops), 64'd4);
        check("mr_beat_cnt", beats_out, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
